// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver with a small receive FIFO and CPU register port.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int unsigned BAUD_DIV   = 78,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       readEnable,
  input  logic       writeEnable,
  input  logic [1:0] regSelect,
  input  logic [7:0] writeData,
  output logic [7:0] Data,
  output logic       rxReady
);

  localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rxs_q, rxs_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         sub_q, sub_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               armed_q, armed_d;
  logic               par_bad_q, par_bad_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovr_q, ovr_d;
  logic               ferr_q, ferr_d;
  logic               perr_q, perr_d;
  logic               re_prev_q, re_prev_d;
  logic               rx_ready_q, rx_ready_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               tick;
  logic               push_req, push_ok, pop, full, not_empty;
  logic               set_ovr, set_ferr, set_perr, wr_status;
  logic [7:0]         rd_data_c;
  logic               unused_c;

  assign unused_c = ^{writeData[7:5], writeData[1:0]};

  // Receive FSM, oversample divider, FIFO bookkeeping and sticky flags.
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = rx;
    rxs_d      = rx_meta_q;
    div_d      = div_q;
    sub_d      = sub_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    armed_d    = armed_q;
    par_bad_d  = par_bad_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    re_prev_d  = readEnable;
    push_req   = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;

    tick  = (div_q == DIV_W'(BAUD_DIV - 1));
    div_d = tick ? '0 : div_q + DIV_W'(1);

    case (state_q)
      S_IDLE: begin
        // Arm only after the line has been seen high, so a held-low line never re-triggers.
        if (rxs_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          sub_d   = 4'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (sub_q == 4'd7) begin
            sub_d = 4'd0;
            if (!rxs_q) begin
              bit_d     = 3'd0;
              par_bad_d = 1'b0;
              state_d   = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            if (^{shreg_q, rxs_q}) begin
              par_bad_d = 1'b1;
              set_perr  = 1'b1;
            end
            state_d = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd15) begin
            state_d = S_IDLE;
            if (!rxs_q) begin
              set_ferr = 1'b1;
            end else if (!par_bad_q) begin
              push_req = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    not_empty = (count_q != '0);
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    pop       = readEnable && !re_prev_q && (regSelect == 2'b00) && not_empty;
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    push_ok   = push_req && (!full || pop);
    set_ovr   = push_req && full && !pop;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);

    // W1C clears first so a coincident set event wins.
    wr_status = writeEnable && (regSelect == 2'b01);
    if (wr_status && writeData[2]) ovr_d  = 1'b0;
    if (wr_status && writeData[3]) ferr_d = 1'b0;
    if (wr_status && writeData[4]) perr_d = 1'b0;
    if (set_ovr)  ovr_d  = 1'b1;
    if (set_ferr) ferr_d = 1'b1;
    if (set_perr) perr_d = 1'b1;

    rx_ready_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      div_q      <= '0;
      sub_q      <= 4'd0;
      bit_q      <= 3'd0;
      shreg_q    <= 8'h00;
      armed_q    <= 1'b0;
      par_bad_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      re_prev_q  <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rxs_q      <= rxs_d;
      div_q      <= div_d;
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      armed_q    <= armed_d;
      par_bad_q  <= par_bad_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      re_prev_q  <= re_prev_d;
      rx_ready_q <= rx_ready_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers and count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shreg_q;
  end

  // Read mux is combinational so the CPU sees the head in the same cycle as the strobe.
  always_comb begin
    rd_data_c = 8'h00;
    case (regSelect)
      2'b00:   rd_data_c = not_empty ? mem_q[rd_ptr_q] : 8'h00;
      2'b01:   rd_data_c = {2'b00, (state_q != S_IDLE), perr_q, ferr_q, ovr_q, full, not_empty};
      2'b10:   rd_data_c = 8'(count_q);
      default: rd_data_c = 8'h00;
    endcase
  end

  assign Data    = readEnable ? rd_data_c : 8'bz;
  assign rxReady = rx_ready_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (BAUD_DIV=4, 64 clk per bit, FIFO_DEPTH=4, default 8N1 build).
module tb_uart_rx;

  localparam int unsigned BIT_CYC = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       readEnable;
  logic       writeEnable;
  logic [1:0] regSelect;
  logic [7:0] writeData;
  wire  [7:0] Data;
  logic       rxReady;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 608;
  logic [7:0] d;

  uart_rx #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .readEnable (readEnable),
    .writeEnable(writeEnable),
    .regSelect  (regSelect),
    .writeData  (writeData),
    .Data       (Data),
    .rxReady    (rxReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start the frame on a fixed divider phase so push timing repeats frame to frame.
  task automatic align();
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CYC);
    end
    rx = stop_bit;
    idle(BIT_CYC);
    rx = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] sel, output logic [7:0] val);
    @(negedge clk);
    regSelect  = sel;
    readEnable = 1'b1;
    #1 val = Data;
    @(negedge clk);
    readEnable = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] val);
    @(negedge clk);
    regSelect   = sel;
    writeData   = val;
    writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; rx = 1'b1; readEnable = 1'b0; writeEnable = 1'b0;
    regSelect = 2'b00; writeData = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(4);

    // Reset state
    check_eq("rst_ready", rxReady, 1'b0);
    reg_read(2'b01, d); check_eq("rst_status", d, 8'h00);
    reg_read(2'b10, d); check_eq("rst_count", d, 8'h00);
    reg_read(2'b00, d); check_eq("rst_rxdata_empty", d, 8'h00);
    reg_read(2'b11, d); check_eq("reg3_read", d, 8'h00);

    // Single 0xA5 frame with latency measurement
    align();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int n;
        n = 0;
        while (!rxReady && n < 1000) begin
          @(negedge clk);
          n++;
        end
        lat = n;
      end
    join
    check_eq("a5_ready", rxReady, 1'b1);
    check_eq("a5_latency_window", (lat >= 604 && lat <= 616), 1'b1);
    if (lat < 2 || lat > 700) lat = 608;
    reg_read(2'b01, d); check_eq("a5_status", d, 8'h01);
    reg_read(2'b10, d); check_eq("a5_count", d, 8'h01);
    reg_read(2'b00, d); check_eq("a5_rxdata", d, 8'hA5);
    check_eq("a5_ready_after_read", rxReady, 1'b0);
    reg_read(2'b10, d); check_eq("a5_count_after_read", d, 8'h00);

    // Short low glitch on idle line
    rx = 1'b0; idle(20); rx = 1'b1; idle(100);
    reg_read(2'b01, d); check_eq("glitch_status", d, 8'h00);
    reg_read(2'b10, d); check_eq("glitch_count", d, 8'h00);

    // Framing error, then W1C
    send_frame(8'h3C, 1'b0);
    idle(8);
    reg_read(2'b01, d); check_eq("ferr_status", d, 8'h08);
    reg_read(2'b10, d); check_eq("ferr_count", d, 8'h00);
    reg_write(2'b01, 8'h08);
    reg_read(2'b01, d); check_eq("ferr_cleared", d, 8'h00);

    // Overflow with five unread bytes
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
    idle(8);
    reg_read(2'b10, d); check_eq("ovr_count", d, 8'h04);
    reg_read(2'b01, d); check_eq("ovr_status", d, 8'h07);
    // Held readEnable pops only once
    @(negedge clk);
    regSelect = 2'b00; readEnable = 1'b1;
    #1 d = Data;
    check_eq("hold_head", d, 8'h01);
    idle(3);
    readEnable = 1'b0;
    reg_read(2'b10, d); check_eq("hold_count", d, 8'h03);
    reg_read(2'b00, d); check_eq("ovr_read2", d, 8'h02);
    reg_read(2'b00, d); check_eq("ovr_read3", d, 8'h03);
    reg_read(2'b00, d); check_eq("ovr_read4", d, 8'h04);
    reg_read(2'b00, d); check_eq("ovr_read_empty", d, 8'h00);
    check_eq("ovr_ready_empty", rxReady, 1'b0);
    reg_write(2'b01, 8'h04);
    reg_read(2'b01, d); check_eq("ovr_cleared", d, 8'h00);

    // Pop in the exact cycle of a push into a full FIFO
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
    idle(8);
    reg_read(2'b01, d); check_eq("full_status", d, 8'h03);
    align();
    fork
      send_frame(8'h05, 1'b1);
      begin
        idle(lat - 1);
        regSelect = 2'b00; readEnable = 1'b1;
        #1 d = Data;
        @(negedge clk);
        readEnable = 1'b0;
        check_eq("race_head", d, 8'h01);
      end
    join
    idle(8);
    reg_read(2'b10, d); check_eq("race_count", d, 8'h04);
    reg_read(2'b01, d); check_eq("race_status_no_ovr", d, 8'h03);
    for (int b = 2; b <= 5; b++) begin
      reg_read(2'b00, d); check_eq("race_drain", d, 8'(b));
    end

    // Reset asserted mid-DATA and held to the end of the frame
    send_frame(8'h42, 1'b1);
    idle(8);
    reg_read(2'b10, d); check_eq("pre_reset_count", d, 8'h01);
    fork
      send_frame(8'h55, 1'b1);
      begin
        idle(200);
        reset = 1'b1;
        idle(4);
        check_eq("reset_ready", rxReady, 1'b0);
      end
    join
    reset = 1'b0;
    idle(8);
    reg_read(2'b10, d); check_eq("post_reset_count", d, 8'h00);
    reg_read(2'b01, d); check_eq("post_reset_status", d, 8'h00);
    check_eq("post_reset_ready", rxReady, 1'b0);
    send_frame(8'h55, 1'b1);
    idle(8);
    reg_read(2'b01, d); check_eq("clean55_status", d, 8'h01);
    reg_read(2'b00, d); check_eq("clean55_rxdata", d, 8'h55);
    reg_read(2'b10, d); check_eq("clean55_count", d, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
